// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of the 4-bit ALU: accepts one register-register
// instruction per 3 cycles, drives registered operands, and writes the ALU result back.
module alu_issue_ctrl #(
  parameter int DATA_W  = 4,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       in_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_slt,
  input  logic              alu_zero,
  output logic              done,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              slt_flag,
  output logic              err,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [4];
  logic [2:0]        op_q;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] imm_q;

  logic [2:0]        in_op;
  logic [1:0]        in_rd;
  logic [1:0]        in_rs1;
  logic [1:0]        in_rs2;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              rd_writable;

  assign in_op  = in_instr[11:9];
  assign in_rd  = in_instr[8:7];
  assign in_rs1 = in_instr[6:5];
  assign in_rs2 = in_instr[4:3];
  assign in_imm = in_instr[3:0];

  assign rs1_val     = (R0_ZERO && in_rs1 == 2'd0) ? '0 : regs[in_rs1];
  assign rs2_val     = (R0_ZERO && in_rs2 == 2'd0) ? '0 : regs[in_rs2];
  assign dbg_data    = (R0_ZERO && dbg_sel == 2'd0) ? '0 : regs[dbg_sel];
  assign rd_writable = !(R0_ZERO && rd_q == 2'd0);

  // Gated by rst so the handshake stays closed during the reset cycle itself.
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      done      <= 1'b0;
      wb_data   <= '0;
      zero_flag <= 1'b0;
      slt_flag  <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= in_op;
            rd_q   <= in_rd;
            imm_q  <= in_imm;
            alu_a  <= rs1_val;
            alu_b  <= rs2_val;
            // LOADI and the illegal opcode never reach the ALU.
            alu_op <= (in_op[2:1] == 2'b11) ? 3'b000 : in_op;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= WB;
        WB: begin
          done  <= 1'b1;
          state <= IDLE;
          case (op_q)
            3'b110: begin
              if (rd_writable) regs[rd_q] <= imm_q;
              wb_data <= imm_q;
            end
            3'b111: begin
              wb_data <= '0;
              err     <= 1'b1;
            end
            default: begin
              if (rd_writable) regs[rd_q] <= alu_result;
              wb_data   <= alu_result;
              zero_flag <= alu_zero;
              slt_flag  <= alu_slt;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU on the far side.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_instr;
  logic [3:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_slt, alu_zero;
  logic        done;
  logic [3:0]  wb_data;
  logic        zero_flag, slt_flag, err;
  logic [1:0]  dbg_sel;
  logic [3:0]  dbg_data;

  int checks = 0;
  int errors = 0;
  int bad_op = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(4), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_slt(alu_slt), .alu_zero(alu_zero), .done(done), .wb_data(wb_data),
    .zero_flag(zero_flag), .slt_flag(slt_flag), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Downstream ALU: signed SLT, Zero_Flag from the result.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = {3'b000, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 4'h0;
    endcase
    alu_slt  = $signed(alu_a) < $signed(alu_b);
    alu_zero = (alu_result == 4'h0);
  end

  always @(negedge clk) if (alu_op === 3'b111) bad_op++;

  function automatic logic [11:0] rr(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [11:0] loadi(input logic [1:0] rd, input logic [3:0] imm);
    return {3'b110, rd, 3'b000, imm};
  endfunction

  // Returns with time just after the edge where done is first seen high;
  // lat counts edges from the accept edge (inclusive) to the done edge.
  task automatic do_instr(input logic [11:0] ins, output int lat);
    int w;
    lat = 0;
    w = 0;
    in_instr = ins;
    in_valid = 1'b1;
    while (!in_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; dbg_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", in_ready); end
    checks++; if ({alu_a, alu_b, alu_op} !== 11'h0) begin errors++; $display("FAIL reset_alu got %h exp 000", {alu_a, alu_b, alu_op}); end
    checks++; if ({done, wb_data, zero_flag, slt_flag, err} !== 8'h0) begin errors++; $display("FAIL reset_outs got %h exp 00", {done, wb_data, zero_flag, slt_flag, err}); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0]; #1;
      checks++; if (dbg_data !== 4'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", i, dbg_data); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loadi_add;
    int lat;
    do_instr(loadi(2'd1, 4'h7), lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL loadi_latency got %0d exp 3", lat); end
    checks++; if (wb_data !== 4'h7) begin errors++; $display("FAIL loadi_wb got %h exp 7", wb_data); end
    do_instr(loadi(2'd2, 4'h9), lat);
    checks++; if (wb_data !== 4'h9) begin errors++; $display("FAIL loadi2_wb got %h exp 9", wb_data); end
    do_instr(rr(3'b000, 2'd3, 2'd1, 2'd2), lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got %0d exp 3", lat); end
    checks++; if ({alu_a, alu_b} !== 8'h79) begin errors++; $display("FAIL add_operands got %h exp 79", {alu_a, alu_b}); end
    checks++; if (wb_data !== 4'h0) begin errors++; $display("FAIL add_wb got %h exp 0", wb_data); end
    checks++; if ({zero_flag, slt_flag} !== 2'b10) begin errors++; $display("FAIL add_flags got %b exp 10", {zero_flag, slt_flag}); end
    dbg_sel = 2'd3; #1;
    checks++; if (dbg_data !== 4'h0) begin errors++; $display("FAIL add_r3 got %h exp 0", dbg_data); end
    dbg_sel = 2'd1; #1;
    checks++; if (dbg_data !== 4'h7) begin errors++; $display("FAIL add_r1 got %h exp 7", dbg_data); end
  endtask

  task automatic test_sub_slt;
    int lat;
    do_instr(loadi(2'd1, 4'h3), lat);
    do_instr(loadi(2'd2, 4'h5), lat);
    do_instr(rr(3'b001, 2'd3, 2'd1, 2'd2), lat);
    checks++; if (wb_data !== 4'hE) begin errors++; $display("FAIL sub_wb got %h exp e", wb_data); end
    checks++; if ({zero_flag, slt_flag} !== 2'b01) begin errors++; $display("FAIL sub_flags got %b exp 01", {zero_flag, slt_flag}); end
    do_instr(rr(3'b101, 2'd0, 2'd1, 2'd2), lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL slt_done got latency %0d exp 3", lat); end
    checks++; if (wb_data !== 4'h1) begin errors++; $display("FAIL slt_wb got %h exp 1", wb_data); end
    checks++; if ({zero_flag, slt_flag} !== 2'b01) begin errors++; $display("FAIL slt_flags got %b exp 01", {zero_flag, slt_flag}); end
    dbg_sel = 2'd0; #1;
    checks++; if (dbg_data !== 4'h0) begin errors++; $display("FAIL slt_r0 got %h exp 0", dbg_data); end
    dbg_sel = 2'd3; #1;
    checks++; if (dbg_data !== 4'hE) begin errors++; $display("FAIL sub_r3 got %h exp e", dbg_data); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] prog [4];
    logic [3:0]  exp_wb [4];
    logic [3:0]  exp_r [4];
    int          acc_cyc [4];
    int          idx, nacc, ndone;
    logic        take;
    @(posedge clk); #1;
    // r1=3, r2=5 on entry; instruction 2 consumes instruction 1's result
    prog[0] = rr(3'b000, 2'd1, 2'd1, 2'd2); exp_wb[0] = 4'h8;
    prog[1] = rr(3'b000, 2'd2, 2'd1, 2'd2); exp_wb[1] = 4'hD;
    prog[2] = rr(3'b100, 2'd3, 2'd2, 2'd1); exp_wb[2] = 4'h5;
    prog[3] = rr(3'b010, 2'd3, 2'd3, 2'd2); exp_wb[3] = 4'h5;
    exp_r[0] = 4'h0; exp_r[1] = 4'h8; exp_r[2] = 4'hD; exp_r[3] = 4'h5;
    idx = 0; nacc = 0; ndone = 0;
    in_instr = prog[0];
    in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      take = in_ready && in_valid;
      if (done) begin
        if (ndone < 4) begin
          checks++; if (wb_data !== exp_wb[ndone]) begin errors++; $display("FAIL b2b_wb%0d got %h exp %h", ndone, wb_data, exp_wb[ndone]); end
        end
        ndone++;
      end
      if (take && nacc < 4) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      @(posedge clk); #1;
      if (take) begin
        idx++;
        if (idx < 4) in_instr = prog[idx];
        else in_valid = 1'b0;
      end
    end
    checks++; if (nacc !== 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", nacc); end
    for (int i = 0; i < nacc; i++) begin
      checks++; if (acc_cyc[i] !== 3 * i) begin errors++; $display("FAIL b2b_accept_cycle%0d got %0d exp %0d", i, acc_cyc[i], 3 * i); end
    end
    checks++; if (ndone !== 4) begin errors++; $display("FAIL b2b_done_count got %0d exp 4", ndone); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0]; #1;
      checks++; if (dbg_data !== exp_r[i]) begin errors++; $display("FAIL b2b_reg%0d got %h exp %h", i, dbg_data, exp_r[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    int lat;
    logic [3:0] exp_r [4];
    exp_r[0] = 4'h0; exp_r[1] = 4'h8; exp_r[2] = 4'hD; exp_r[3] = 4'h5;
    do_instr(rr(3'b001, 2'd0, 2'd1, 2'd2), lat);
    checks++; if (wb_data !== 4'hB) begin errors++; $display("FAIL pre_ill_wb got %h exp b", wb_data); end
    do_instr({3'b111, 2'd1, 2'd1, 2'd2, 3'b000}, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ill_done got latency %0d exp 3", lat); end
    checks++; if (wb_data !== 4'h0) begin errors++; $display("FAIL ill_wb got %h exp 0", wb_data); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", err); end
    checks++; if ({zero_flag, slt_flag} !== 2'b01) begin errors++; $display("FAIL ill_flags got %b exp 01", {zero_flag, slt_flag}); end
    checks++; if (alu_op !== 3'b000) begin errors++; $display("FAIL ill_alu_op got %b exp 000", alu_op); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ill_done_pulse got %b exp 0", done); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0]; #1;
      checks++; if (dbg_data !== exp_r[i]) begin errors++; $display("FAIL ill_reg%0d got %h exp %h", i, dbg_data, exp_r[i]); end
    end
    @(posedge clk); #1;
    do_instr(rr(3'b000, 2'd0, 2'd1, 2'd1), lat);
    checks++; if (wb_data !== 4'h0) begin errors++; $display("FAIL post_ill_wb got %h exp 0", wb_data); end
    checks++; if ({zero_flag, slt_flag} !== 2'b10) begin errors++; $display("FAIL post_ill_flags got %b exp 10", {zero_flag, slt_flag}); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    checks++; if (bad_op !== 0) begin errors++; $display("FAIL alu_op_111_seen got %0d exp 0", bad_op); end
  endtask

  task automatic test_reset_abort;
    int d;
    in_instr = rr(3'b000, 2'd1, 2'd2, 2'd3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", in_ready); end
    checks++; if ({err, zero_flag, slt_flag} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b exp 000", {err, zero_flag, slt_flag}); end
    d = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) d++;
    end
    checks++; if (d !== 0) begin errors++; $display("FAIL abort_late_done got %0d exp 0", d); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0]; #1;
      checks++; if (dbg_data !== 4'h0) begin errors++; $display("FAIL abort_reg%0d got %h exp 0", i, dbg_data); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_instr_change;
    int lat;
    do_instr(loadi(2'd1, 4'h4), lat);
    do_instr(loadi(2'd2, 4'h2), lat);
    in_instr = rr(3'b000, 2'd3, 2'd1, 2'd2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = loadi(2'd1, 4'hF);
    @(posedge clk); #1;
    in_instr = rr(3'b001, 2'd3, 2'd2, 2'd1);
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL chg_done got %b exp 1", done); end
    checks++; if (wb_data !== 4'h6) begin errors++; $display("FAIL chg_wb got %h exp 6", wb_data); end
    dbg_sel = 2'd1; #1;
    checks++; if (dbg_data !== 4'h4) begin errors++; $display("FAIL chg_r1 got %h exp 4", dbg_data); end
    dbg_sel = 2'd3; #1;
    checks++; if (dbg_data !== 4'h6) begin errors++; $display("FAIL chg_r3 got %h exp 6", dbg_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_loadi_add;
    test_sub_slt;
    test_back_to_back;
    test_illegal;
    test_reset_abort;
    test_instr_change;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing stage directly upstream of the 4-bit ALU; it also owns ALU writeback.
- Accepts 12-bit register-register instructions over a valid/ready handshake and reads operands from a 4-entry DATA_W-bit register file.
- Drives registered operands and opcode into the ALU, then captures Result/SLT_Flag/Zero_Flag into the register file and a flag register.
- Processes one instruction at a time: 3-cycle occupancy, no hazards.

Parameters:
- DATA_W, 4: operand/register width. Must equal the ALU width; 4 is the only supported value.
- R0_ZERO, 1: 1 = r0 reads as 0 and writes to it are discarded; 0 = r0 is an ordinary register.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Instruction present on in_instr.
- in_ready  output  1  Block can accept an instruction.
- in_instr  input  12  Fields: [11:9] op, [8:7] rd, [6:5] rs1, [4:3] rs2, [3:0] imm (LOADI only), [2:0] reserved otherwise.
- alu_a  output  4  Registered operand A to the ALU.
- alu_b  output  4  Registered operand B to the ALU.
- alu_op  output  3  Registered ALU OpCode.
- alu_result  input  4  ALU Result; combinational from alu_a/alu_b/alu_op.
- alu_slt  input  1  ALU SLT_Flag.
- alu_zero  input  1  ALU Zero_Flag.
- done  output  1  One-cycle pulse when an instruction retires.
- wb_data  output  4  Value written back; valid while done=1.
- zero_flag  output  1  Zero flag of the last retired ALU op.
- slt_flag  output  1  SLT flag of the last retired ALU op.
- err  output  1  Sticky: an illegal op (111) was accepted.
- dbg_sel  input  2  Register-file read select.
- dbg_data  output  4  Combinational read of register dbg_sel; honours R0_ZERO.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE; all 4 registers clear to 0.
  - alu_a=alu_b=0, alu_op=000, done=0, wb_data=0, zero_flag=0, slt_flag=0, err=0.
  - in_ready=0 during the reset cycle and 1 in the first cycle after rst deasserts.
  - Reset mid-instruction aborts it: no writeback, no done pulse.
- FSM states: IDLE, ISSUE, WB.
  - IDLE: in_ready=1. On in_valid&in_ready, latch op/rd/imm, load alu_a=reg[rs1], alu_b=reg[rs2], alu_op=op[2:0], then go to ISSUE. If in_valid=0, stay in IDLE.
  - ISSUE: in_ready=0. alu_a/b/op are stable and the ALU settles combinationally. Always go to WB next cycle.
  - WB: in_ready=0. Perform the writeback below, pulse done=1, return to IDLE.
- WB actions by op:
  - op 000-101 (ADD/SUB/AND/OR/XOR/SLT): reg[rd]=alu_result, wb_data=alu_result, zero_flag=alu_zero, slt_flag=alu_slt.
  - op 110 (LOADI): reg[rd]=imm, wb_data=imm. Flags unchanged. alu_op is held at 000 during ISSUE, so 110 never reaches the ALU.
  - op 111 (illegal): no register write, flags unchanged, wb_data=0, err set to 1, done still pulses. alu_op is held at 000 (the ALU would output X).
- Width and read rules:
  - All arithmetic is done in the ALU; this block performs no arithmetic and never widens or truncates.
  - rd=0 with R0_ZERO=1: done and wb_data behave normally, but reg[0] stays 0 and reads of r0 return 0.
- Timing:
  - Latency is 3 cycles from the accept edge to the done edge.
  - Maximum throughput is 1 instruction per 3 cycles.
  - in_valid may be held high continuously; the next instruction is accepted in the IDLE cycle after WB.
- Read-after-write: an instruction accepted right after WB sees the updated register, because the write lands at the WB edge, before the next IDLE accept edge.
- Idle outputs: alu_a/b/op hold their last values; wb_data holds its last value; done=0.
- Handshake: in_instr is sampled only on the accept edge; changes while in_ready=0 are ignored.

Test Plan:
- Reset, then LOADI r1=0x7 and LOADI r2=0x9; then ADD r3,r1,r2 -> done 3 cycles after accept, wb_data=0x0, zero_flag=1, dbg_data(r3)=0x0.
- With r1=0x3, r2=0x5: SUB r3,r1,r2 -> wb_data=0xE, zero_flag=0. Then SLT r0,r1,r2 with R0_ZERO=1 -> done pulses, wb_data=0x1, slt_flag=1, dbg_data(r0)=0x0.
- Hold in_valid=1 for 4 back-to-back instructions -> in_ready is high exactly 1 cycle in 3, done pulses exactly 4 times, and instruction 2 reads the result of instruction 1.
- Issue op 111 -> err=1 and stays 1 across later legal ops, no register changes, flags unchanged, done pulses once, alu_op never 111.
- Assert rst in the ISSUE cycle of ADD r1,r2,r3 -> no done pulse, all registers 0, err/flags 0, in_ready=1 the cycle after rst drops.
- Change in_instr while in_ready=0 -> no effect on the in-flight result or on the register file.
